// File: rtl/cc_board_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cc_board_engine
// Purpose  : N x N candy-board engine. Loads a board of colour codes plus NS
//            striped-candy records, applies a burst of player actions (swap
//            right, swap down, detonate, resolve-only), clears every matched
//            run after each action, and reports the accumulated score once
//            per game through a one-cycle result strobe.
// Ports    : clk             - single rising-edge clock
//            rst_n           - synchronous active-low reset
//            in_valid_1      - board-load beat valid (one cell per beat)
//            in_color        - colour of the current load cell (0 = empty)
//            in_stripe       - stripe direction of record (0 row, 1 column)
//            in_starting_pos - {row, col}: stripe position while loading,
//                              cursor while acting
//            in_valid_2      - action beat valid
//            in_action       - 00 swap right, 01 swap down, 10 detonate,
//                              11 resolve-only
//            out_valid       - one-cycle result strobe
//            out_score       - game score, 0 whenever out_valid is low
// Revision : 1.0 - initial release
// ============================================================================
module cc_board_engine #(
  parameter int N  = 6,
  parameter int CW = 3,
  parameter int NS = 4,
  parameter int SW = 7,
  // Derived field width of one row/column coordinate; leave at default.
  parameter int PW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_1,
  input  logic [CW-1:0]   in_color,
  input  logic            in_stripe,
  input  logic [2*PW-1:0] in_starting_pos,
  input  logic            in_valid_2,
  input  logic [1:0]      in_action,
  output logic            out_valid,
  output logic [SW-1:0]   out_score
);

  localparam int CELLS = N * N;
  localparam int CNT_W = $clog2(CELLS);
  localparam int SMAX  = (1 << SW) - 1;
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(CELLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  // Board storage, flattened row-major: cell (r,c) lives at r*N+c.
  logic [CW-1:0]   color  [CELLS];
  logic            stripe [CELLS];
  logic            dir    [CELLS];
  logic [2*PW-1:0] rec_pos [NS];
  logic            rec_dir [NS];
  logic [CNT_W-1:0] cnt;
  logic             acted;
  logic [SW-1:0]    score;

  logic load_beat;
  logic last_beat;
  logic act_beat;

  assign load_beat = in_valid_1 && ((state == IDLE) || (state == LOAD));
  assign last_beat = load_beat && (cnt == LAST_CELL);
  assign act_beat  = in_valid_2 && (state == ACT);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_score = '0;
    case (state)
      IDLE: if (in_valid_1) state_nx = LOAD;
      LOAD: if (last_beat) state_nx = ACT;
      ACT:  if (!in_valid_2 && acted) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        out_score = score;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Stripe flags at the end of the load. The beat being sampled right now may
  // itself carry a record (when NS covers the whole board), so it is merged in
  // before the records are applied in order; later records overwrite earlier.
  // --------------------------------------------------------------------------
  logic            ld_stripe [CELLS];
  logic            ld_dir    [CELLS];
  logic [2*PW-1:0] eff_pos;
  logic            eff_dir;
  int              lr, lc;

  always_comb begin
    eff_pos = '0;
    eff_dir = 1'b0;
    lr = 0;
    lc = 0;
    for (int i = 0; i < CELLS; i++) begin
      ld_stripe[i] = 1'b0;
      ld_dir[i]    = 1'b0;
    end
    for (int k = 0; k < NS; k++) begin
      if (load_beat && (cnt == CNT_W'(k))) begin
        eff_pos = in_starting_pos;
        eff_dir = in_stripe;
      end else begin
        eff_pos = rec_pos[k];
        eff_dir = rec_dir[k];
      end
      lr = int'(eff_pos[2*PW-1:PW]);
      lc = int'(eff_pos[PW-1:0]);
      if ((lr < N) && (lc < N)) begin
        ld_stripe[lr*N+lc] = 1'b1;
        ld_dir[lr*N+lc]    = eff_dir;
      end
    end
  end

  // --------------------------------------------------------------------------
  // One complete action: move, detonate, match, one-level stripe expansion,
  // score and clear -- all within the cycle the action is sampled.
  // --------------------------------------------------------------------------
  logic [CW-1:0] mv_col [CELLS];
  logic          mv_str [CELLS];
  logic          mv_dir [CELLS];
  logic          det    [CELLS];
  logic          mat    [CELLS];
  logic          expd   [CELLS];
  logic          mark   [CELLS];
  logic [CW-1:0] nx_col [CELLS];
  logic          nx_str [CELLS];
  logic          nx_dir [CELLS];
  logic [SW-1:0] nx_score;
  logic [CW-1:0] t_col;
  logic          t_str, t_dir;
  int            ar, ac, ia, ib, gain, sum;

  always_comb begin
    ar = int'(in_starting_pos[2*PW-1:PW]);
    ac = int'(in_starting_pos[PW-1:0]);
    ia = 0;
    ib = 0;
    gain = 0;
    sum = 0;
    t_col = '0;
    t_str = 1'b0;
    t_dir = 1'b0;
    nx_score = score;
    for (int i = 0; i < CELLS; i++) begin
      mv_col[i] = color[i];
      mv_str[i] = stripe[i];
      mv_dir[i] = dir[i];
      det[i]    = 1'b0;
      mat[i]    = 1'b0;
      expd[i]   = 1'b0;
      mark[i]   = 1'b0;
      nx_col[i] = color[i];
      nx_str[i] = stripe[i];
      nx_dir[i] = dir[i];
    end

    // Step 1: swap with the right or lower neighbour when both are on-board.
    if (((in_action == 2'b00) && (ar < N) && (ac < N - 1)) ||
        ((in_action == 2'b01) && (ar < N - 1) && (ac < N))) begin
      ia = ar * N + ac;
      ib = (in_action == 2'b00) ? ia + 1 : ia + N;
      t_col = mv_col[ia];  t_str = mv_str[ia];  t_dir = mv_dir[ia];
      mv_col[ia] = mv_col[ib]; mv_str[ia] = mv_str[ib]; mv_dir[ia] = mv_dir[ib];
      mv_col[ib] = t_col;      mv_str[ib] = t_str;      mv_dir[ib] = t_dir;
    end

    // Step 2: detonation of a striped cursor cell.
    if ((in_action == 2'b10) && (ar < N) && (ac < N) && mv_str[ar*N+ac]) begin
      for (int j = 0; j < N; j++) begin
        if (mv_dir[ar*N+ac]) det[j*N+ac] = 1'b1;
        else                 det[ar*N+j] = 1'b1;
      end
    end

    // Step 3: any window of three equal nonzero colours marks all three; a
    // longer run is covered by its overlapping windows.
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N - 2; c++) begin
        if ((mv_col[r*N+c] != '0) &&
            (mv_col[r*N+c] == mv_col[r*N+c+1]) &&
            (mv_col[r*N+c] == mv_col[r*N+c+2])) begin
          mat[r*N+c]   = 1'b1;
          mat[r*N+c+1] = 1'b1;
          mat[r*N+c+2] = 1'b1;
        end
        if ((mv_col[c*N+r] != '0) &&
            (mv_col[c*N+r] == mv_col[(c+1)*N+r]) &&
            (mv_col[c*N+r] == mv_col[(c+2)*N+r])) begin
          mat[c*N+r]     = 1'b1;
          mat[(c+1)*N+r] = 1'b1;
          mat[(c+2)*N+r] = 1'b1;
        end
      end
    end

    // Step 4: only match-marked stripes expand; expansion does not chain.
    for (int i = 0; i < CELLS; i++) begin
      if (mat[i] && mv_str[i]) begin
        for (int j = 0; j < N; j++) begin
          if (mv_dir[i]) expd[j*N + (i % N)] = 1'b1;
          else           expd[(i / N)*N + j] = 1'b1;
        end
      end
    end

    // Step 5: score nonzero marked cells, then clear them.
    for (int i = 0; i < CELLS; i++) begin
      mark[i] = det[i] | mat[i] | expd[i];
      if (mark[i] && (mv_col[i] != '0)) gain = gain + 1;
      nx_col[i] = mark[i] ? '0   : mv_col[i];
      nx_str[i] = mark[i] ? 1'b0 : mv_str[i];
      nx_dir[i] = mark[i] ? 1'b0 : mv_dir[i];
    end
    sum = int'(score) + gain;
    nx_score = (sum > SMAX) ? SW'(SMAX) : SW'(sum);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) begin
        color[i]  <= '0;
        stripe[i] <= 1'b0;
        dir[i]    <= 1'b0;
      end
      for (int k = 0; k < NS; k++) begin
        rec_pos[k] <= '0;
        rec_dir[k] <= 1'b0;
      end
      cnt   <= '0;
      acted <= 1'b0;
      score <= '0;
    end else begin
      if (load_beat) begin
        for (int i = 0; i < CELLS; i++) begin
          if (cnt == CNT_W'(i)) color[i] <= in_color;
        end
        for (int k = 0; k < NS; k++) begin
          if (cnt == CNT_W'(k)) begin
            rec_pos[k] <= in_starting_pos;
            rec_dir[k] <= in_stripe;
          end
        end
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
      if (last_beat) begin
        stripe <= ld_stripe;
        dir    <= ld_dir;
      end
      if ((state == IDLE) && in_valid_1) begin
        score <= '0;
        acted <= 1'b0;
      end
      if (act_beat) begin
        color  <= nx_col;
        stripe <= nx_str;
        dir    <= nx_dir;
        score  <= nx_score;
        acted  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cc_board_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cc_board_engine
// Purpose  : Self-checking bench for cc_board_engine. Two instances share all
//            inputs: the base configuration (SW=7) and a narrow-score one
//            (SW=3) that shows saturation. Expected scores come from a
//            board-level reference model working on a 2-D grid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cc_board_engine;

  localparam int N     = 6;
  localparam int CW    = 3;
  localparam int NS    = 4;
  localparam int PW    = 3;
  localparam int CELLS = N * N;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid_1;
  logic [CW-1:0]   in_color;
  logic            in_stripe;
  logic [2*PW-1:0] in_starting_pos;
  logic            in_valid_2;
  logic [1:0]      in_action;
  logic            out_valid, out_valid_s;
  logic [6:0]      out_score;
  logic [2:0]      out_score_s;

  always #5 clk = ~clk;

  cc_board_engine #(.N(N), .CW(CW), .NS(NS), .SW(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_1(in_valid_1), .in_color(in_color),
    .in_stripe(in_stripe), .in_starting_pos(in_starting_pos),
    .in_valid_2(in_valid_2), .in_action(in_action),
    .out_valid(out_valid), .out_score(out_score)
  );

  cc_board_engine #(.N(N), .CW(CW), .NS(NS), .SW(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid_1(in_valid_1), .in_color(in_color),
    .in_stripe(in_stripe), .in_starting_pos(in_starting_pos),
    .in_valid_2(in_valid_2), .in_action(in_action),
    .out_valid(out_valid_s), .out_score(out_score_s)
  );

  int checks   = 0;
  int failures = 0;

  // Game description: board colours, stripe records, action list.
  int g_col [CELLS];
  int g_rr [NS], g_rc [NS], g_rd [NS];
  int q_a [$], q_r [$], q_c [$];

  // Reference model state.
  int m_col [N][N];
  bit m_sf  [N][N];
  bit m_sd  [N][N];
  int m_big, m_small;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_load;
    for (int i = 0; i < CELLS; i++) m_col[i / N][i % N] = g_col[i];
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_sf[r][c] = 1'b0;
        m_sd[r][c] = 1'b0;
      end
    for (int k = 0; k < NS; k++)
      if (g_rr[k] < N && g_rc[k] < N) begin
        m_sf[g_rr[k]][g_rc[k]] = 1'b1;
        m_sd[g_rr[k]][g_rc[k]] = g_rd[k][0];
      end
    m_big   = 0;
    m_small = 0;
  endtask

  task automatic model_swap(input int r0, input int c0, input int r1, input int c1);
    int t; bit b;
    t = m_col[r0][c0]; m_col[r0][c0] = m_col[r1][c1]; m_col[r1][c1] = t;
    b = m_sf[r0][c0];  m_sf[r0][c0]  = m_sf[r1][c1];  m_sf[r1][c1]  = b;
    b = m_sd[r0][c0];  m_sd[r0][c0]  = m_sd[r1][c1];  m_sd[r1][c1]  = b;
  endtask

  task automatic model_act(input int a, input int r, input int c);
    bit det [N][N];
    bit mat [N][N];
    bit mk  [N][N];
    int gained, e;
    gained = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        det[i][j] = 0; mat[i][j] = 0; mk[i][j] = 0;
      end
    if (a == 0 && r < N && c + 1 < N) model_swap(r, c, r, c + 1);
    if (a == 1 && r + 1 < N && c < N) model_swap(r, c, r + 1, c);
    if (a == 2 && r < N && c < N && m_sf[r][c])
      for (int k = 0; k < N; k++) begin
        if (m_sd[r][c]) det[k][c] = 1;
        else            det[r][k] = 1;
      end
    // Run-length scan of every row and column.
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < N; s = e + 1) begin
        e = s;
        while (e + 1 < N && m_col[i][e + 1] == m_col[i][s]) e++;
        if (m_col[i][s] != 0 && e - s + 1 >= 3)
          for (int k = s; k <= e; k++) mat[i][k] = 1;
      end
      for (int s = 0; s < N; s = e + 1) begin
        e = s;
        while (e + 1 < N && m_col[e + 1][i] == m_col[s][i]) e++;
        if (m_col[s][i] != 0 && e - s + 1 >= 3)
          for (int k = s; k <= e; k++) mat[k][i] = 1;
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mk[i][j] = det[i][j] | mat[i][j];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mat[i][j] && m_sf[i][j])
          for (int k = 0; k < N; k++) begin
            if (m_sd[i][j]) mk[k][j] = 1;
            else            mk[i][k] = 1;
          end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mk[i][j]) begin
          if (m_col[i][j] != 0) gained++;
          m_col[i][j] = 0; m_sf[i][j] = 0; m_sd[i][j] = 0;
        end
    m_big   = (m_big + gained > 127) ? 127 : m_big + gained;
    m_small = (m_small + gained > 7) ? 7 : m_small + gained;
  endtask

  task automatic drive_load(input bit stall, input bit noise);
    logic [31:0] rr, rc;
    model_load();
    for (int i = 0; i < CELLS; i++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid_1 = 1'b0;
          in_valid_2 = noise ? 1'($urandom) : 1'b0;
          in_action  = 2'($urandom);
          tick();
        end
      end
      in_valid_1 = 1'b1;
      in_color   = CW'(g_col[i]);
      if (i < NS) begin
        rr = g_rr[i]; rc = g_rc[i];
        in_stripe       = g_rd[i][0];
        in_starting_pos = {rr[2:0], rc[2:0]};
      end else begin
        in_stripe       = 1'($urandom);
        in_starting_pos = 6'($urandom);
      end
      in_valid_2 = noise ? 1'($urandom) : 1'b0;
      tick();
    end
  endtask

  task automatic drive_actions(input bit noise);
    logic [31:0] rr, rc, aa;
    for (int j = 0; j < q_a.size(); j++) begin
      rr = q_r[j]; rc = q_c[j]; aa = q_a[j];
      in_valid_1      = noise ? 1'($urandom) : 1'b0;
      in_color        = 3'($urandom);
      in_valid_2      = 1'b1;
      in_action       = aa[1:0];
      in_starting_pos = {rr[2:0], rc[2:0]};
      model_act(q_a[j], q_r[j], q_c[j]);
      tick();
    end
  endtask

  // exp_big / exp_small < 0 means: compare against the model only.
  task automatic check_result(input string name, input int exp_big, input int exp_small);
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s.early out_valid=%b want 0", name, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_valid_s !== 1'b1) begin
      failures++;
      $display("FAIL %s.strobe out_valid=%b/%b want 1/1", name, out_valid, out_valid_s);
    end
    checks++;
    if (out_score !== 7'(m_big) || out_score_s !== 3'(m_small)) begin
      failures++;
      $display("FAIL %s.score got=%0d/%0d model=%0d/%0d", name, out_score, out_score_s, m_big, m_small);
    end
    if (exp_big >= 0) begin
      checks++;
      if (out_score !== 7'(exp_big) || out_score_s !== 3'(exp_small)) begin
        failures++;
        $display("FAIL %s.value got=%0d/%0d want=%0d/%0d", name, out_score, out_score_s, exp_big, exp_small);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_score !== 7'd0 || out_valid_s !== 1'b0 || out_score_s !== 3'd0) begin
      failures++;
      $display("FAIL %s.after out_valid=%b out_score=%0d want 0/0", name, out_valid, out_score);
    end
  endtask

  task automatic play_game(input string name, input int eb, input int es,
                           input bit stall, input bit noise);
    drive_load(stall, noise);
    drive_actions(noise);
    check_result(name, eb, es);
  endtask

  task automatic set_checker(input int a, input int b);
    for (int i = 0; i < CELLS; i++) g_col[i] = (((i / N) + (i % N)) % 2) ? b : a;
    for (int k = 0; k < NS; k++) begin
      g_rr[k] = 7; g_rc[k] = k; g_rd[k] = 0;
    end
    q_a.delete(); q_r.delete(); q_c.delete();
  endtask

  task automatic add_act(input int a, input int r, input int c);
    q_a.push_back(a); q_r.push_back(r); q_c.push_back(c);
  endtask

  task automatic setup_row0_swap;
    set_checker(5, 6);
    g_col[0] = 1; g_col[1] = 1; g_col[2] = 2; g_col[3] = 1; g_col[4] = 3; g_col[5] = 4;
    add_act(0, 0, 2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid_1 = 0; in_valid_2 = 0; in_color = 0; in_stripe = 0;
    in_starting_pos = 0; in_action = 0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_score !== 7'd0 || out_valid_s !== 1'b0 || out_score_s !== 3'd0) begin
      failures++;
      $display("FAIL reset out_valid=%b out_score=%0d want 0/0", out_valid, out_score);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_score !== 7'd0) begin
      failures++;
      $display("FAIL reset_release out_valid=%b out_score=%0d want 0/0", out_valid, out_score);
    end
  endtask

  task automatic test_no_match;
    set_checker(1, 2);
    add_act(3, 0, 0);
    play_game("no_match", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_swap_match;
    setup_row0_swap();
    play_game("swap_match", 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_stripe_expand;
    set_checker(1, 2);
    g_col[1*N+2] = 5; g_col[2*N+2] = 5; g_col[3*N+2] = 5;
    g_rr[0] = 2; g_rc[0] = 2; g_rd[0] = 0;
    add_act(3, 0, 0);
    play_game("stripe_expand", 8, 7, 1'b0, 1'b0);
  endtask

  task automatic test_detonate;
    set_checker(1, 2);
    g_rr[0] = 1; g_rc[0] = 4; g_rd[0] = 1;
    add_act(2, 1, 4);
    add_act(2, 1, 4);
    play_game("detonate", 6, 6, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_act;
    setup_row0_swap();
    add_act(3, 0, 0);
    drive_load(1'b0, 1'b0);
    drive_actions(1'b0);
    rst_n = 1'b0;
    in_valid_2 = 1'b1;
    tick();
    rst_n = 1'b1;
    in_valid_2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b0 || out_valid_s !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_act.cycle%0d out_valid=%b want 0", k, out_valid);
      end
      tick();
    end
    setup_row0_swap();
    play_game("after_reset", 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_random_games;
    int na, pick;
    for (int g = 0; g < 30; g++) begin
      for (int i = 0; i < CELLS; i++) g_col[i] = $urandom_range(0, 4);
      for (int k = 0; k < NS; k++) begin
        g_rr[k] = $urandom_range(0, 7);
        g_rc[k] = $urandom_range(0, 6);
        g_rd[k] = $urandom_range(0, 1);
      end
      q_a.delete(); q_r.delete(); q_c.delete();
      na = $urandom_range(1, 6);
      for (int j = 0; j < na; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          pick = $urandom_range(0, NS - 1);
          add_act($urandom_range(0, 3), g_rr[pick], g_rc[pick]);
        end else begin
          add_act($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
        end
      end
      play_game($sformatf("random%0d", g), -1, -1, 1'b1, 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    // Two games with no idle gap between the result strobe and the next load.
    setup_row0_swap();
    play_game("b2b_first", 3, 3, 1'b0, 1'b0);
    set_checker(1, 2);
    g_rr[0] = 1; g_rc[0] = 4; g_rd[0] = 1;
    add_act(2, 1, 4);
    play_game("b2b_second", 6, 6, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_match();
    test_swap_match();
    test_stripe_expand();
    test_detonate();
    test_reset_mid_act();
    test_back_to_back();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
